// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing a + b + cin one bit per clock,
// LSB first, under a three-state IDLE/RUN/DONE controller.
//
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   rst   - asynchronous active-high reset (clears every register)
//   start - request to begin an addition, accepted only in IDLE
//   a, b  - WIDTH-bit operands, captured on the accepting edge
//   cin   - carry-in, captured on the accepting edge
//   busy  - high while bits are being processed (RUN)
//   done  - one-cycle pulse when sum/cout/ovf have just been updated
//   sum   - registered result, modulo 2^WIDTH
//   cout  - registered carry out of bit WIDTH-1
//   ovf   - registered two's-complement overflow flag
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] res_nxt;
  logic             last_bit;

  // One-bit full adder: returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | ((x ^ y) & c), x ^ y ^ c};
  endfunction

  always_comb begin
    {carry_nxt, sum_bit} = full_add(a_sh[0], b_sh[0], carry);
    // Result bits enter at the MSB end so that after WIDTH shifts the
    // LSB-first stream lands in natural bit order.
    res_nxt  = {sum_bit, res[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_nxt;
          carry <= carry_nxt;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            // On the MSB, 'carry' is the carry into bit WIDTH-1 and
            // carry_nxt the carry out of it; their XOR is signed overflow.
            sum   <= res_nxt;
            cout  <= carry_nxt;
            ovf   <= carry ^ carry_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder at WIDTH 8, 4 and 16.
// Directed cases plus randomized operations compared against an arithmetic
// reference model (integer addition and signed range test).
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic       start4, cin4, busy4, done4, cout4, ovf4;
  logic [3:0] a4, b4, sum4;

  logic        start16, cin16, busy16, done16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [7:0] r_sum;
  logic       r_cout, r_ovf;

  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition, plus signed-range test for overflow.
  task automatic ref_add(input int w, input longint a, input longint b, input longint c,
                         output longint s, output longint co, output longint ov);
    longint m, full, sa, sb, ss;
    m    = longint'(1) << w;
    full = a + b + c;
    s    = full % m;
    co   = full / m;
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    ss   = sa + sb + c;
    ov   = (ss >= m / 2 || ss < -(m / 2)) ? 1 : 0;
  endtask

  // One WIDTH=8 operation with latency / busy-length checks.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n, nb;
    longint es, ec, eo;
    bit seen;
    ref_add(8, longint'(a), longint'(b), longint'(c), es, ec, eo);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0; nb = 0; seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (busy8) nb++;
      if (done8) seen = 1;
    end
    if (!seen) check("op8_timeout", 0, 1);
    else begin
      check("op8_latency", n, 9);
      check("op8_busy_len", nb, 8);
      check("op8_busy_at_done", busy8, 0);
      check("op8_sum", sum8, es);
      check("op8_cout", cout8, ec);
      check("op8_ovf", ovf8, eo);
      r_sum = sum8; r_cout = cout8; r_ovf = ovf8;
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n;
    longint es, ec, eo;
    ref_add(4, longint'(a), longint'(b), longint'(c), es, ec, eo);
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; cin4 = c;
    @(posedge clk);
    #1 start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 20);
    if (!done4) check("op4_timeout", 0, 1);
    else begin
      check("op4_latency", n, 5);
      check("op4_sum", sum4, es);
      check("op4_cout", cout4, ec);
      check("op4_ovf", ovf4, eo);
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n;
    longint es, ec, eo;
    ref_add(16, longint'(a), longint'(b), longint'(c), es, ec, eo);
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; cin16 = c;
    @(posedge clk);
    #1 start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!done16 && n < 30);
    if (!done16) check("op16_timeout", 0, 1);
    else begin
      check("op16_latency", n, 17);
      check("op16_sum", sum16, es);
      check("op16_cout", cout16, ec);
      check("op16_ovf", ovf16, eo);
    end
  endtask

  initial begin
    int ndone, last_cyc, n;
    bit got;
    rst = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    start16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout_ovf", {cout8, ovf8}, 0);
    check("rst_w4_w16", {busy4, done4, sum4, busy16, done16, sum16}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=8 cases
    op8(8'h5A, 8'h33, 1'b0);
    check("d1_sum", r_sum, 8'h8D); check("d1_cout", r_cout, 0); check("d1_ovf", r_ovf, 1);
    op8(8'hFF, 8'h01, 1'b0);
    check("d2_sum", r_sum, 8'h00); check("d2_cout", r_cout, 1); check("d2_ovf", r_ovf, 0);
    op8(8'h7F, 8'h00, 1'b1);
    check("d3_sum", r_sum, 8'h80); check("d3_cout", r_cout, 0); check("d3_ovf", r_ovf, 1);

    // start during RUN is ignored; operands changing mid-flight do not matter
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    ndone = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy8 && done8) check("busy_done_overlap", 1, 0);
      if (done8) begin
        ndone++;
        check("ign_sum", sum8, 8'h30);
        check("ign_cout_ovf", {cout8, ovf8}, 0);
      end
    end
    check("ign_done_count", ndone, 1);

    // Asynchronous reset mid-RUN aborts the operation
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy8, 0);
    check("arst_sum", sum8, 0);
    check("arst_flags", {done8, cout8, ovf8}, 0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("arst_no_done", ndone, 0);
    op8(8'h01, 8'h01, 1'b0);
    check("post_rst_sum", r_sum, 8'h02);

    // start held high: back-to-back issue every WIDTH+2 cycles
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
    last_cyc = 0;
    for (int p = 0; p < 4; p++) begin
      n = 0; got = 0;
      while (n < 15 && !got) begin
        @(negedge clk);
        n++;
        if (done8) got = 1;
        else if (p > 0) check("hold_sum_stable", sum8, 8'h00);
      end
      if (!got) begin
        check("hold_timeout", 0, 1);
        break;
      end
      check("hold_sum", sum8, 8'h00);
      check("hold_cout_ovf", {cout8, ovf8}, 2'b11);
      if (p > 0) check("hold_interval", cyc - last_cyc, 10);
      last_cyc = cyc;
    end
    start8 = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 200; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    fork
      for (int i = 0; i < 1000; i++)
        op4(4'($urandom), 4'($urandom), 1'($urandom));
      for (int j = 0; j < 1000; j++)
        op16(16'($urandom), 16'($urandom), 1'($urandom));
    join

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  augend, captured only on an accepted start.
REQ-006 b  input  WIDTH  addend, captured only on an accepted start.
REQ-007 cin  input  1  carry-in, captured only on an accepted start.
REQ-008 busy  output  1  high while bits are being processed (RUN state).
REQ-009 done  output  1  one-cycle pulse, result valid and updated.
REQ-010 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry out of bit WIDTH-1.
REQ-012 ovf  output  1  registered two's-complement overflow flag.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE: start=1 at an edge SHALL load a, b into internal shift registers, cin into the carry flop, clear the bit counter, and move to RUN.
REQ-015 IDLE with start=0 SHALL remain in IDLE with no state change.
REQ-016 RUN: each edge SHALL process exactly one bit, LSB first: bit = a_i ^ b_i ^ c; c_next = (a_i & b_i) | ((a_i ^ b_i) & c).
REQ-017 RUN: the computed bit SHALL shift into an internal result register from the MSB end, and the operand registers SHALL shift right by one.
REQ-018 RUN: the counter SHALL increment per bit; on the edge that processes bit WIDTH-1, the FSM SHALL move to DONE.
REQ-019 On the RUN->DONE edge, sum, cout, and ovf SHALL load simultaneously.
  - sum = the completed result register.
  - cout = final carry.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-020 sum, cout, and ovf SHALL hold their previous values throughout RUN, changing only on the RUN->DONE edge.
REQ-021 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-022 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both SHALL never be high together.
REQ-023 Latency: if start is accepted at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1.
REQ-024 start asserted in RUN or DONE SHALL be ignored (no reload, no restart, no queueing).
REQ-025 start held high continuously SHALL be accepted at the first IDLE edge after each DONE, giving an issue interval of WIDTH+2 cycles.
REQ-026 Changes on a, b, or cin after the accepting edge SHALL NOT affect the in-flight result.
REQ-027 Arithmetic SHALL wrap modulo 2^WIDTH, with cout/ovf as the only indication of range exceedance.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force:
  - FSM to IDLE;
  - busy=0, done=0, sum=0, cout=0, ovf=0;
  - counter, carry flop, and shift registers to 0.
REQ-029 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-030 After rst deasserts, the first start SHALL be accepted at the first rising edge with start=1.

Verification
REQ-031 WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy for 8 cycles, done at cycle 8; sum=0x8D, cout=0, ovf=1.
REQ-032 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
REQ-033 Start operation a=0x10, b=0x20; pulse start with a=0xFF, b=0xFF during RUN cycle 3 -> result remains sum=0x30, cout=0, ovf=0, done pulses exactly once.
REQ-034 rst asserted asynchronously mid-cycle during RUN cycle 4 -> all outputs 0 immediately; no done pulse; next start with a=0x01, b=0x01 -> sum=0x02.
REQ-035 start held high with a=0x80, b=0x80, cin=0 -> done pulses every 10 cycles; sum=0x00, cout=1, ovf=1 each time; sum stable between done pulses.
REQ-036 Randomized: 1000 operations each at WIDTH=4 and WIDTH=16 -> {cout,sum} equals a+b+cin and ovf equals signed overflow on every done pulse.
